// File: rtl/rr_stream_pkg.sv
// Shared types and helpers for the round-robin packet-locked stream arbiter.
package rr_stream_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Index width that stays at least one bit wide for a single requester.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotated priority encoder: first set request at or after ptr, wrapping modulo NUM_REQ.
module rr_priority_pick
    import rr_stream_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDW    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     idx,
    output logic               any
);

    logic [IDW-1:0]       w_base;
    logic [2*NUM_REQ-1:0] w_req_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    int                   w_off;
    int                   w_sum;

    // Doubling the vector lets a plain shift express the wrap for any NUM_REQ.
    assign w_base    = (int'(ptr) < NUM_REQ) ? ptr : '0;
    assign w_req_dbl = {req, req};
    assign w_rot     = NUM_REQ'(w_req_dbl >> w_base);

    always_comb begin
        any   = 1'b0;
        w_off = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any && w_rot[k]) begin
                any   = 1'b1;
                w_off = k;
            end
        end
        w_sum = int'(w_base) + w_off;
        if (w_sum >= NUM_REQ) begin
            w_sum = w_sum - NUM_REQ;
        end
        idx = IDW'(w_sum);
    end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Round-robin arbiter sharing one valid/ready stream; grants are held for a whole packet
// and the output is a registered forward stage.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no grant; all RxRdy low; pick next winner from ptr onward
// ST_BUSY | grant held; RxRdy[grant] follows output stage space until last beat
module rr_stream_arbiter
    import rr_stream_pkg::*;
#(
    parameter int  NUM_REQ  = 4,
    parameter int  BITWIDTH = 8,
    localparam int IDW      = id_width(NUM_REQ)
) (
    input  logic                        clki,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          RxVld,
    input  logic [NUM_REQ*BITWIDTH-1:0] RxData,
    input  logic [NUM_REQ-1:0]          RxLast,
    output logic [NUM_REQ-1:0]          RxRdy,
    output logic                        TxVld,
    output logic [BITWIDTH-1:0]         TxData,
    output logic                        TxLast,
    output logic [IDW-1:0]              TxId,
    input  logic                        TxRdy
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDW-1:0]      r_ptr;
    logic [IDW-1:0]      r_grant;
    logic [IDW-1:0]      w_pick_idx;
    logic [IDW-1:0]      w_ptr_nxt;
    logic                w_pick_any;
    logic                w_sel_vld;
    logic                w_sel_last;
    logic [BITWIDTH-1:0] w_sel_data;
    logic                w_grant_rdy;
    logic                w_accept;
    logic                w_load_grant;
    logic                w_release;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req (RxVld),
        .ptr (r_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    always_comb begin
        w_sel_vld  = 1'b0;
        w_sel_last = 1'b0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant == IDW'(i)) begin
                w_sel_vld  = RxVld[i];
                w_sel_last = RxLast[i];
                w_sel_data = RxData[i*BITWIDTH +: BITWIDTH];
            end
        end
    end

    // Space in the output stage: empty, or draining this cycle.
    assign w_grant_rdy = ~TxVld | TxRdy;
    assign w_ptr_nxt   = (r_grant == IDW'(NUM_REQ - 1)) ? '0 : r_grant + IDW'(1);

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load_grant = 1'b0;
        w_release    = 1'b0;
        w_accept     = 1'b0;
        RxRdy        = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_load_grant = 1'b1;
                    w_state_nxt  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    RxRdy[i] = (r_grant == IDW'(i)) & w_grant_rdy;
                end
                w_accept = w_sel_vld & w_grant_rdy;
                if (w_accept && w_sel_last) begin
                    w_release   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            if (w_load_grant) begin
                r_grant <= w_pick_idx;
            end
            if (w_release) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            TxVld  <= 1'b0;
            TxData <= '0;
            TxLast <= 1'b0;
            TxId   <= '0;
        end else if (w_accept) begin
            TxVld  <= 1'b1;
            TxData <= w_sel_data;
            TxLast <= w_sel_last;
            TxId   <= r_grant;
        end else if (TxRdy) begin
            TxVld  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Self-checking bench for rr_stream_arbiter: directed vector table, multi-cycle corner sequences
// and a randomized soak with per-requester scoreboards.
module tb_rr_stream_arbiter;

    localparam int N = 4;

    logic         clki = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] RxVld, RxLast, RxRdy;
    logic [31:0]  RxData;
    logic         TxVld, TxLast, TxRdy;
    logic [7:0]   TxData;
    logic [1:0]   TxId;

    logic [2:0]   r3_vld, r3_last, r3_rdy;
    logic [23:0]  r3_data;
    logic         t3_vld, t3_last, t3_rdy;
    logic [7:0]   t3_data;
    logic [1:0]   t3_id;

    rr_stream_arbiter #(.NUM_REQ(4), .BITWIDTH(8)) u_dut (
        .clki(clki), .rst_n(rst_n), .RxVld(RxVld), .RxData(RxData), .RxLast(RxLast),
        .RxRdy(RxRdy), .TxVld(TxVld), .TxData(TxData), .TxLast(TxLast), .TxId(TxId), .TxRdy(TxRdy)
    );

    rr_stream_arbiter #(.NUM_REQ(3), .BITWIDTH(8)) u_dut3 (
        .clki(clki), .rst_n(rst_n), .RxVld(r3_vld), .RxData(r3_data), .RxLast(r3_last),
        .RxRdy(r3_rdy), .TxVld(t3_vld), .TxData(t3_data), .TxLast(t3_last), .TxId(t3_id), .TxRdy(t3_rdy)
    );

    always #5 clki = ~clki;

    typedef struct {
        logic [3:0]  vld;
        logic [3:0]  last;
        logic [31:0] data;
        logic        txrdy;
        logic [3:0]  e_rdy;
        logic        e_vld;
        logic [7:0]  e_data;
        logic [1:0]  e_id;
        logic        e_last;
    } vec_t;

    vec_t        vecs[13];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [7:0]  q_data[N][$];
    logic        q_last[N][$];
    logic [7:0]  e_data[N][$];
    logic        e_last[N][$];
    logic [7:0]  o_data[$];
    logic [1:0]  o_id[$];
    logic        o_last[$];
    int          o_cyc[$];
    logic [N-1:0] acc_prev, held, in_pkt, waiting;
    int          wait_cnt[N];
    logic        hold_prev;
    logic [10:0] hold_snap;
    logic        out_in_pkt;
    logic [1:0]  out_owner;
    logic        chk_fair;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic clear_tb_state();
        for (int i = 0; i < N; i++) begin
            q_data[i].delete(); q_last[i].delete();
            e_data[i].delete(); e_last[i].delete();
            wait_cnt[i] = 0;
        end
        o_data.delete(); o_id.delete(); o_last.delete(); o_cyc.delete();
        acc_prev = '0; held = '0; in_pkt = '0; waiting = '0;
        hold_prev = 1'b0; hold_snap = '0;
        out_in_pkt = 1'b0; out_owner = '0; chk_fair = 1'b0;
    endtask

    task automatic drive_idle();
        RxVld = '0; RxLast = '0; RxData = '0; TxRdy = 1'b1;
        r3_vld = '0; r3_last = '0; r3_data = '0; t3_rdy = 1'b1;
    endtask

    task automatic do_reset();
        drive_idle();
        clear_tb_state();
        rst_n = 1'b0;
        repeat (2) @(posedge clki);
        #3 rst_n = 1'b1;
    endtask

    // One clock of queue-driven stimulus; valid stays up until accepted once raised.
    task automatic cycle(input logic [N-1:0] en, input logic rdy);
        @(posedge clki);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (acc_prev[i] && q_data[i].size() > 0) begin
                void'(q_data[i].pop_front());
                in_pkt[i] = ~q_last[i].pop_front();
            end
            if (q_data[i].size() > 0) begin
                RxVld[i] = en[i] | held[i];
                RxData[i*8 +: 8] = q_data[i][0];
                RxLast[i] = q_last[i][0];
            end else begin
                RxVld[i] = 1'b0;
                RxData[i*8 +: 8] = 8'h00;
                RxLast[i] = 1'b0;
            end
        end
        TxRdy = rdy;
        #4;
        check("rxrdy_onehot", 64'($countones(RxRdy) <= 1), 64'd1);
        if (hold_prev) check("hold_stable", {TxVld, TxData, TxId, TxLast}, {1'b1, hold_snap});
        if (TxVld && TxRdy) begin
            o_data.push_back(TxData); o_id.push_back(TxId);
            o_last.push_back(TxLast); o_cyc.push_back(cyc);
            if (out_in_pkt) begin
                check("pkt_contig", TxId, out_owner);
            end else if (chk_fair) begin
                for (int i = 0; i < N; i++) begin
                    if (i != int'(TxId) && waiting[i]) begin
                        wait_cnt[i]++;
                        check("fair_wait", 64'(wait_cnt[i] <= N), 64'd1);
                    end
                end
                waiting[TxId] = 1'b0;
                wait_cnt[TxId] = 0;
            end
            out_owner = TxId;
            out_in_pkt = ~TxLast;
        end
        hold_prev = TxVld & ~TxRdy;
        hold_snap = {TxData, TxId, TxLast};
        for (int i = 0; i < N; i++) begin
            acc_prev[i] = RxVld[i] & RxRdy[i];
            held[i] = RxVld[i] & ~RxRdy[i];
            if (RxVld[i] && !in_pkt[i]) waiting[i] = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] lk_d[5];
        logic [1:0] lk_id[5];
        logic       lk_l[5];
        logic       done;
        int         gap_left;
        int         seq;
        int         left;

        //            vld     last    data          rdy   e_rdy   e_vld e_data e_id  e_last
        vecs[0]  = '{4'b0001, 4'b0001, 32'h00000010, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
        vecs[1]  = '{4'b0001, 4'b0001, 32'h00000010, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0};
        vecs[2]  = '{4'b0110, 4'b0100, 32'h00312100, 1'b1, 4'b0000, 1'b1, 8'h10, 2'd0, 1'b1};
        vecs[3]  = '{4'b0110, 4'b0100, 32'h00312100, 1'b1, 4'b0010, 1'b0, 8'h00, 2'd0, 1'b0};
        vecs[4]  = '{4'b0110, 4'b0110, 32'h00312200, 1'b0, 4'b0000, 1'b1, 8'h21, 2'd1, 1'b0};
        vecs[5]  = '{4'b0110, 4'b0110, 32'h00312200, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1, 1'b0};
        vecs[6]  = '{4'b0101, 4'b0101, 32'h00310011, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1, 1'b1};
        vecs[7]  = '{4'b0101, 4'b0101, 32'h00310011, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1, 1'b1};
        vecs[8]  = '{4'b0101, 4'b0101, 32'h00310011, 1'b1, 4'b0100, 1'b1, 8'h22, 2'd1, 1'b1};
        vecs[9]  = '{4'b0001, 4'b0001, 32'h00000011, 1'b1, 4'b0000, 1'b1, 8'h31, 2'd2, 1'b1};
        vecs[10] = '{4'b0001, 4'b0001, 32'h00000011, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0};
        vecs[11] = '{4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'h11, 2'd0, 1'b1};
        vecs[12] = '{4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};

        do_reset();
        check("reset_tx", {TxVld, TxData, TxId, TxLast}, 64'd0);
        check("reset_rxrdy", RxRdy, 64'd0);

        for (int v = 0; v < 13; v++) begin
            @(posedge clki);
            #1;
            RxVld = vecs[v].vld; RxLast = vecs[v].last; RxData = vecs[v].data; TxRdy = vecs[v].txrdy;
            #4;
            check($sformatf("vec%0d_rxrdy", v), RxRdy, vecs[v].e_rdy);
            check($sformatf("vec%0d_txvld", v), TxVld, vecs[v].e_vld);
            if (vecs[v].e_vld)
                check($sformatf("vec%0d_beat", v), {TxData, TxId, TxLast},
                      {vecs[v].e_data, vecs[v].e_id, vecs[v].e_last});
        end

        // Reset asserted mid-packet: requester 1, beat 2 of 4 being accepted.
        drive_idle();
        for (int b = 0; b < 4; b++) begin
            q_data[1].push_back(8'(8'h71 + b)); q_last[1].push_back(b == 3);
        end
        repeat (3) cycle(4'b0010, 1'b1);
        check("mid_rdy_before", RxRdy, 4'b0010);
        check("mid_tx_before", {TxVld, TxData}, {1'b1, 8'h71});
        rst_n = 1'b0;
        #1;
        check("rst_async_rxrdy", RxRdy, 64'd0);
        check("rst_async_tx", {TxVld, TxData, TxId, TxLast}, 64'd0);
        clear_tb_state();
        drive_idle();
        @(posedge clki);
        #3 rst_n = 1'b1;
        q_data[0].push_back(8'h80); q_last[0].push_back(1'b1);
        q_data[1].push_back(8'h90); q_last[1].push_back(1'b1);
        cycle(4'b0011, 1'b1);
        check("post_rst_idle", RxRdy, 64'd0);
        cycle(4'b0011, 1'b1);
        check("post_rst_grant0", RxRdy, 4'b0001);

        // Fairness: every requester always valid, single-beat packets.
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++) begin
                q_data[i].push_back(8'(8'h40 + i)); q_last[i].push_back(1'b1);
            end
        for (int c = 0; c < 40 && o_data.size() < 8; c++) cycle(4'hF, 1'b1);
        check("fair_count", o_data.size(), 8);
        for (int k = 0; k < 8 && k < o_data.size(); k++) begin
            check($sformatf("fair_id%0d", k), o_id[k], k % 4);
            check($sformatf("fair_data%0d", k), o_data[k], 8'h40 + (k % 4));
            if (k > 0) check($sformatf("fair_gap%0d", k), o_cyc[k] - o_cyc[k-1], 2);
        end

        // Packet lock with a two-cycle valid gap, requester 0 requesting throughout.
        do_reset();
        for (int b = 0; b < 10; b++) begin
            q_data[0].push_back(8'h50); q_last[0].push_back(1'b1);
        end
        q_data[2].push_back(8'hA1); q_last[2].push_back(1'b0);
        q_data[2].push_back(8'hA2); q_last[2].push_back(1'b0);
        q_data[2].push_back(8'hA3); q_last[2].push_back(1'b1);
        gap_left = 0;
        for (int c = 0; c < 25; c++) begin
            if (acc_prev[2] && q_data[2].size() == 3) gap_left = 2;
            if (gap_left > 0) begin
                gap_left--;
                cycle(4'b0001, 1'b1);
            end else begin
                cycle(4'b0101, 1'b1);
            end
        end
        lk_d  = '{8'h50, 8'hA1, 8'hA2, 8'hA3, 8'h50};
        lk_id = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd0};
        lk_l  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        check("lock_count", 64'(o_data.size() >= 5), 64'd1);
        for (int k = 0; k < 5 && k < o_data.size(); k++)
            check($sformatf("lock_beat%0d", k), {o_data[k], o_id[k], o_last[k]}, {lk_d[k], lk_id[k], lk_l[k]});

        // Backpressure for five cycles in the middle of a four-beat packet.
        do_reset();
        for (int b = 0; b < 4; b++) begin
            q_data[1].push_back(8'(8'h61 + b)); q_last[1].push_back(b == 3);
        end
        for (int c = 0; c < 14; c++) begin
            cycle(4'b0010, !(c >= 4 && c < 9));
            if (c >= 4 && c < 9) begin
                check($sformatf("bp_rxrdy%0d", c), RxRdy, 64'd0);
                check($sformatf("bp_tx%0d", c), {TxVld, TxData}, {1'b1, 8'h63});
            end
        end
        check("bp_count", o_data.size(), 4);
        for (int k = 0; k < 4 && k < o_data.size(); k++)
            check($sformatf("bp_beat%0d", k), {o_data[k], o_id[k], o_last[k]}, {8'(8'h61 + k), 2'd1, k == 3});

        // Non-power-of-two wrap on the three-requester instance.
        do_reset();
        @(posedge clki); #1;
        r3_vld = 3'b010; r3_last = 3'b010; r3_data = 24'h00B100;
        #4 check("w3_idle", r3_rdy, 3'b000);
        @(posedge clki); #5;
        check("w3_grant1", r3_rdy, 3'b010);
        @(posedge clki); #1;
        r3_vld = 3'b011; r3_last = 3'b011; r3_data = 24'h00B2C0;
        #4 check("w3_tx1", {t3_vld, t3_data, t3_id}, {1'b1, 8'hB1, 2'd1});
        @(posedge clki); #5;
        check("w3_wrap_grant0", r3_rdy, 3'b001);
        @(posedge clki); #5;
        check("w3_tx0", {t3_vld, t3_data, t3_id}, {1'b1, 8'hC0, 2'd0});
        @(posedge clki); #5;
        check("w3_grant1b", r3_rdy, 3'b010);
        @(posedge clki); #1;
        r3_vld = '0; r3_last = '0;
        #4 check("w3_tx1b", {t3_vld, t3_data, t3_id}, {1'b1, 8'hB2, 2'd1});

        // Random soak with per-requester scoreboards.
        do_reset();
        chk_fair = 1'b1;
        for (int i = 0; i < N; i++) begin
            seq = 0;
            for (int p = 0; p < 6; p++) begin
                int len;
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) begin
                    logic [7:0] d;
                    d = {2'(i), 6'(seq)};
                    seq++;
                    q_data[i].push_back(d); q_last[i].push_back(b == len - 1);
                    e_data[i].push_back(d); e_last[i].push_back(b == len - 1);
                end
            end
        end
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            cycle(4'($urandom), $urandom_range(0, 9) < 7);
            done = (q_data[0].size() == 0) && (q_data[1].size() == 0) &&
                   (q_data[2].size() == 0) && (q_data[3].size() == 0) && !TxVld;
        end
        check("soak_done", done, 1'b1);
        for (int k = 0; k < o_data.size(); k++) begin
            if (e_data[o_id[k]].size() == 0) begin
                check("soak_extra_beat", {o_data[k], o_id[k]}, 64'hFFFF);
            end else begin
                check("soak_beat", {o_data[k], o_last[k]}, {e_data[o_id[k]][0], e_last[o_id[k]][0]});
                void'(e_data[o_id[k]].pop_front());
                void'(e_last[o_id[k]].pop_front());
            end
        end
        left = 0;
        for (int i = 0; i < N; i++) left += e_data[i].size();
        check("soak_missing", left, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
